// File: rtl/weight_bram_sequencer.sv
// Write/read sequencer for one single-port weight BRAM (negedge-clocked, 1-deep read).
// LOAD streams DEPTH words into addresses 0..DEPTH-1; FETCH streams them back to the MAC with LAST.
module weight_bram_sequencer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          LD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic          LD_DONE,
  input  logic          FETCH_START,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic          BUSY,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          w_valid_q, w_valid_d;
  logic          w_last_q, w_last_d;
  logic          ld_done_q, ld_done_d;
  logic          issue;
  logic          ld_ready_c, bram_en_c, bram_we_c;
  logic [AW-1:0] bram_addr_c;
  logic [DW-1:0] bram_di_c;

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      w_valid_q <= w_valid_d;
      w_last_q  <= w_last_d;
      ld_done_q <= ld_done_d;
    end
  end

  // Next-state, counter updates and BRAM port drive
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    w_valid_d   = w_valid_q;
    w_last_d    = w_last_q;
    ld_done_d   = 1'b0;
    issue       = 1'b0;
    ld_ready_c  = 1'b0;
    bram_en_c   = 1'b0;
    bram_we_c   = 1'b0;
    bram_addr_c = '0;
    bram_di_c   = '0;

    case (state_q)
      IDLE: begin
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        if (LD_START) begin
          state_d = LOAD;
        end else if (FETCH_START) begin
          state_d = FETCH;
        end
      end

      LOAD: begin
        ld_ready_c  = 1'b1;
        bram_en_c   = LD_VALID;
        bram_we_c   = LD_VALID;
        bram_addr_c = wr_cnt_q;
        bram_di_c   = LD_DATA;
        if (LD_VALID) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d  = '0;
            ld_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end

      FETCH: begin
        // Only read when the output slot is free or being emptied, so BRAM_DO holds under stall
        issue       = !w_valid_q || W_READY;
        bram_en_c   = issue;
        bram_addr_c = rd_cnt_q;
        if (issue) begin
          w_valid_d = 1'b1;
          w_last_d  = (rd_cnt_q == LAST_IDX);
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
          end
        end
      end

      DRAIN: begin
        if (w_valid_q && W_READY && w_last_q) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep the BRAM quiet while reset is asserted so its contents survive a mid-pass reset
    if (!RST_N) begin
      ld_ready_c  = 1'b0;
      bram_en_c   = 1'b0;
      bram_we_c   = 1'b0;
      bram_addr_c = '0;
      bram_di_c   = '0;
    end
  end

  assign LD_READY  = ld_ready_c;
  assign LD_DONE   = ld_done_q;
  assign W_DATA    = BRAM_DO;
  assign W_VALID   = w_valid_q;
  assign W_LAST    = w_last_q;
  assign BUSY      = (state_q != IDLE);
  assign BRAM_ADDR = bram_addr_c;
  assign BRAM_DI   = bram_di_c;
  assign BRAM_EN   = bram_en_c;
  assign BRAM_WE   = bram_we_c;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge BRAM model and an expected-beat scoreboard.
module tb_weight_bram_sequencer;

  localparam int unsigned DEPTH = 28;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;

  logic          CLK;
  logic          RST_N;
  logic          LD_START;
  logic          LD_VALID;
  logic [DW-1:0] LD_DATA;
  logic          LD_READY;
  logic          LD_DONE;
  logic          FETCH_START;
  logic [DW-1:0] W_DATA;
  logic          W_VALID;
  logic          W_READY;
  logic          W_LAST;
  logic          BUSY;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DO;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;

  weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY), .LD_DONE(LD_DONE),
    .FETCH_START(FETCH_START),
    .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST),
    .BUSY(BUSY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DO(BRAM_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port BRAM, negedge-clocked, read-first, 1-deep output register
  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
      BRAM_DO <= mem[BRAM_ADDR];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_w_valid"},  32'(W_VALID),   32'd0);
    chk({tag, "_w_last"},   32'(W_LAST),    32'd0);
    chk({tag, "_ld_done"},  32'(LD_DONE),   32'd0);
    chk({tag, "_busy"},     32'(BUSY),      32'd0);
    chk({tag, "_ld_ready"}, 32'(LD_READY),  32'd0);
    chk({tag, "_bram_en"},  32'(BRAM_EN),   32'd0);
    chk({tag, "_bram_we"},  32'(BRAM_WE),   32'd0);
    chk({tag, "_addr"},     32'(BRAM_ADDR), 32'd0);
    chk({tag, "_di"},       32'(BRAM_DI),   32'd0);
  endtask

  // LOAD pass: a word offered every 'gap' cycles; optionally a same-cycle and a mid-load FETCH_START
  task automatic run_load(input logic [DW-1:0] base, input int gap, input bit with_fetch);
    int i;
    int cyc;
    logic [DW-1:0] d;
    i   = 0;
    cyc = 0;
    LD_START    = 1'b1;
    FETCH_START = with_fetch;
    tick();
    LD_START    = 1'b0;
    FETCH_START = 1'b0;
    while (i < int'(DEPTH) && cyc < 400) begin
      d = base + DW'(i);
      if (cyc % gap == 0) begin
        LD_VALID = 1'b1;
        LD_DATA  = d;
      end else begin
        LD_VALID = 1'b0;
        LD_DATA  = 16'hDEAD;
      end
      FETCH_START = with_fetch && (cyc == 1);
      #1;
      chk("load_ready", 32'(LD_READY), 32'd1);
      chk("load_busy",  32'(BUSY),     32'd1);
      chk("load_done_low", 32'(LD_DONE), 32'd0);
      if (LD_VALID) begin
        chk("load_en",   32'(BRAM_EN),   32'd1);
        chk("load_we",   32'(BRAM_WE),   32'd1);
        chk("load_addr", 32'(BRAM_ADDR), 32'(i));
        chk("load_di",   32'(BRAM_DI),   32'(d));
        model[i] = d;
        i++;
      end else begin
        chk("load_gap_en", 32'(BRAM_EN), 32'd0);
        chk("load_gap_we", 32'(BRAM_WE), 32'd0);
      end
      tick();
      cyc++;
    end
    chk("load_budget", 32'(i), 32'(DEPTH));
    LD_VALID    = 1'b0;
    FETCH_START = 1'b0;
    #1;
    chk("ld_done_pulse", 32'(LD_DONE),  32'd1);
    chk("ld_done_busy",  32'(BUSY),     32'd0);
    chk("ld_done_ready", 32'(LD_READY), 32'd0);
    tick();
    chk("ld_done_once",  32'(LD_DONE),  32'd0);
    chk("post_load_busy", 32'(BUSY),    32'd0);
    chk("post_load_w_valid", 32'(W_VALID), 32'd0);
  endtask

  // FETCH pass: optional stall of stall_len cycles at beat stall_at, optional reset at beat reset_at
  task automatic run_fetch(input int stall_at, input int stall_len, input int reset_at);
    int beats;
    int stalled;
    int cyc;
    bit done;
    beat_t e;
    beats   = 0;
    stalled = 0;
    cyc     = 0;
    done    = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      e.data = model[k];
      e.last = (k == int'(DEPTH) - 1);
      exp_q.push_back(e);
    end
    FETCH_START = 1'b1;
    W_READY     = 1'b1;
    tick();
    FETCH_START = 1'b0;
    #1;
    chk("fetch_latency_valid", 32'(W_VALID),   32'd0);
    chk("fetch_busy",          32'(BUSY),      32'd1);
    chk("fetch_first_en",      32'(BRAM_EN),   32'd1);
    chk("fetch_first_we",      32'(BRAM_WE),   32'd0);
    chk("fetch_first_addr",    32'(BRAM_ADDR), 32'd0);
    tick();
    while (!done && cyc < 200) begin
      if (beats == reset_at) begin
        RST_N   = 1'b0;
        W_READY = 1'b1;
        tick();
        RST_N = 1'b1;
        #1;
        chk_idle_outputs("reset");
        exp_q.delete();
        return;
      end
      W_READY = !(beats == stall_at && stalled < stall_len);
      #1;
      chk("fetch_valid", 32'(W_VALID), 32'd1);
      if (!W_READY) begin
        chk("stall_hold_data", 32'(W_DATA),  32'(exp_q[0].data));
        chk("stall_en",        32'(BRAM_EN), 32'd0);
        stalled++;
      end else begin
        e = exp_q.pop_front();
        chk("fetch_data", 32'(W_DATA), 32'(e.data));
        chk("fetch_last", 32'(W_LAST), 32'(e.last));
        beats++;
        if (e.last) done = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("fetch_budget", 32'(done), 32'd1);
    chk("fetch_beats",  32'(beats), 32'(DEPTH));
    chk("post_fetch_valid", 32'(W_VALID), 32'd0);
    chk("post_fetch_last",  32'(W_LAST),  32'd0);
    chk("post_fetch_busy",  32'(BUSY),    32'd0);
    chk("post_fetch_en",    32'(BRAM_EN), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    RST_N       = 1'b0;
    LD_START    = 1'b0;
    LD_VALID    = 1'b0;
    LD_DATA     = '0;
    FETCH_START = 1'b0;
    W_READY     = 1'b0;
    tick();
    tick();
    chk_idle_outputs("por");
    RST_N = 1'b1;
    tick();
    chk("idle_busy", 32'(BUSY), 32'd0);

    // Contiguous load 0x0001..0x001C, then straight fetch
    run_load(16'h0001, 1, 1'b0);
    run_fetch(-1, 0, -1);

    // Fetch with a 3-cycle MAC stall on beat 5
    run_fetch(5, 3, -1);

    // Gapped load (one word in three), verified by a fetch
    run_load(16'h0100, 3, 1'b0);
    run_fetch(-1, 0, -1);

    // Simultaneous starts pick LOAD; FETCH_START during LOAD is ignored
    run_load(16'h0001, 2, 1'b1);

    // Reset at fetch beat 10, then a clean full pass from 0x0001
    run_fetch(-1, 0, 10);
    tick();
    run_fetch(-1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
